// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: constants shared by the fetch stage, next-PC logic and hazard unit.
//   PC_RESET_DEFAULT - PC after reset
//   IM_BASE_DEFAULT  - lowest legal fetch address
//   IM_TOP_DEFAULT   - highest legal (word-aligned) fetch address
//   NOP_INSTR        - encoding loaded into IF/ID for bubbles and bad fetches
package pc_fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_DEFAULT   = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bundle between the fetch stage and its surroundings
// (next-PC logic, hazard unit, instruction memory, decode stage).
//   npc, stall, flush, im_rdata          - into the fetch stage
//   im_addr, pc_f, instr_d, pc_d, pc8_d,
//   valid_d, adel_d, fetch_cnt           - out of the fetch stage
// Modports: master = fetch stage, slave = environment.
interface pc_fetch_unit_if;

    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        adel_d;
    logic [31:0] fetch_cnt;

    modport master (
        input  npc, stall, flush, im_rdata,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, adel_d, fetch_cnt
    );

    modport slave (
        output npc, stall, flush, im_rdata,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, adel_d, fetch_cnt
    );

endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// pc_fetch_unit_pc_reg: the architectural PC register (sub-block pc_reg of the fetch stage).
//   clk   - clock
//   reset - synchronous active-high reset, loads RESET_VAL
//   en_i  - load d_i on the rising edge
//   d_i   - next PC
//   q_o   - current PC
module pc_fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction-fetch stage. Holds the PC, drives the instruction
// memory address, commits the externally computed next PC and registers the fetched
// word into IF/ID. Edge priority: reset > flush > stall > normal.
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - pc_fetch_unit_if.master (npc/stall/flush/im_rdata in; im_addr, pc_f,
//           IF/ID fields, adel_d and fetch_cnt out)
// Optional build macro FETCH_ADDR_CHECK_EN: flag misaligned or out-of-range fetches,
// turning them into NOPs with adel_d set. Without it adel_d is constant 0.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_TOP   = IM_TOP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_fetch_unit_if.master        bus
);

    logic [31:0] pc_f;
    logic        pc_en;
    logic        adel_f;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc8_q, pc8_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;
    logic [31:0] cnt_q, cnt_d;

    // Flush still advances the PC even when the hazard unit asks for a stall.
    assign pc_en = bus.flush | ~bus.stall;

    pc_fetch_unit_pc_reg #(
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (pc_en),
        .d_i   (bus.npc),
        .q_o   (pc_f)
    );

`ifdef FETCH_ADDR_CHECK_EN
    assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_TOP);
`else
    assign adel_f = 1'b0;
    logic unused_params;
    assign unused_params = ^{IM_BASE, IM_TOP};
`endif

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            // Bubble: the counter only tracks committed fetches, so it holds.
            instr_d = NOP_INSTR;
            pcd_d   = 32'h0;
            pc8_d   = 32'h0;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (!bus.stall) begin
            instr_d = adel_f ? NOP_INSTR : bus.im_rdata;
            pcd_d   = pc_f;
            pc8_d   = pc_f + 32'd8;
            valid_d = 1'b1;
            adel_d  = adel_f;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'h0;
            pc8_q   <= 32'h0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.im_addr   = pc_f;
    assign bus.pc_f      = pc_f;
    assign bus.instr_d   = instr_q;
    assign bus.pc_d      = pcd_q;
    assign bus.pc8_d     = pc8_q;
    assign bus.valid_d   = valid_q;
    assign bus.adel_d    = adel_q;
    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit. Instruction memory returns
// im_addr ^ 32'hDEAD_0000 so each fetched word identifies its address.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.im_rdata = bus.im_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                            input logic [31:0] pcd, input logic [31:0] pc8,
                            input logic vld, input logic adl, input logic [31:0] cnt);
        chk({tag, ".pc_f"},      bus.pc_f, pcf);
        chk({tag, ".im_addr"},   bus.im_addr, pcf);
        chk({tag, ".instr_d"},   bus.instr_d, ins);
        chk({tag, ".pc_d"},      bus.pc_d, pcd);
        chk({tag, ".pc8_d"},     bus.pc8_d, pc8);
        chk({tag, ".valid_d"},   {31'h0, bus.valid_d}, {31'h0, vld});
        chk({tag, ".adel_d"},    {31'h0, bus.adel_d}, {31'h0, adl});
        chk({tag, ".fetch_cnt"}, bus.fetch_cnt, cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.npc   = 32'h0000_1234;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk_ifid("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // Sequential fetch, npc = pc_f + 4.
        reset = 1'b0;
        bus.npc = 32'h3004; step();
        chk_ifid("seq1", 32'h3004, 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1, 1'b0, 32'd1);
        bus.npc = 32'h3008; step();
        chk_ifid("seq2", 32'h3008, 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1, 1'b0, 32'd2);
        bus.npc = 32'h300C; step();
        chk_ifid("seq3", 32'h300C, 32'hDEAD_3008, 32'h3008, 32'h3010, 1'b1, 1'b0, 32'd3);
        bus.npc = 32'h3010; step();
        chk_ifid("seq4", 32'h3010, 32'hDEAD_300C, 32'h300C, 32'h3014, 1'b1, 1'b0, 32'd4);

        // Jump back to 0x3008, then stall there for three edges.
        bus.npc = 32'h3008; step();
        chk_ifid("jmp", 32'h3008, 32'hDEAD_3010, 32'h3010, 32'h3018, 1'b1, 1'b0, 32'd5);
        bus.stall = 1'b1;
        bus.npc   = 32'h3400;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'h3008, 32'hDEAD_3010, 32'h3010, 32'h3018, 1'b1, 1'b0, 32'd5);
        end
        bus.stall = 1'b0; step();
        chk_ifid("unstall", 32'h3400, 32'hDEAD_3008, 32'h3008, 32'h3010, 1'b1, 1'b0, 32'd6);

        // Flush overrides stall; PC still loads npc, IF/ID becomes a bubble.
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        bus.npc   = 32'h4180; step();
        chk_ifid("flush", 32'h4180, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        // npc wiggles between edges; only the value at the edge matters.
        bus.npc = 32'h6000;
        #2 bus.npc = 32'h5000;
        step();
        chk_ifid("post_flush", 32'h5000, 32'hDEAD_4180, 32'h4180, 32'h4188, 1'b1, 1'b0, 32'd7);

        // Reset while stalled.
        reset     = 1'b1;
        bus.stall = 1'b1;
        bus.npc   = 32'h0000_5555; step();
        chk_ifid("mid_reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        bus.npc   = 32'h3004; step();
        chk_ifid("first_fetch", 32'h3004, 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1, 1'b0, 32'd1);

        // Misaligned then out-of-range fetch addresses.
        bus.npc = 32'h3002; step();
        chk_ifid("pre_bad", 32'h3002, 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1, 1'b0, 32'd2);
        bus.npc = 32'h7000; step();
`ifdef FETCH_ADDR_CHECK_EN
        chk_ifid("misalign", 32'h7000, 32'h0, 32'h3002, 32'h300A, 1'b1, 1'b1, 32'd3);
`else
        chk_ifid("misalign", 32'h7000, 32'hDEAD_3002, 32'h3002, 32'h300A, 1'b1, 1'b0, 32'd3);
`endif
        bus.npc = 32'h3000; step();
`ifdef FETCH_ADDR_CHECK_EN
        chk_ifid("above_top", 32'h3000, 32'h0, 32'h7000, 32'h7008, 1'b1, 1'b1, 32'd4);
`else
        chk_ifid("above_top", 32'h3000, 32'hDEAD_7000, 32'h7000, 32'h7008, 1'b1, 1'b0, 32'd4);
`endif
        bus.npc = 32'h3004; step();
        chk_ifid("adel_clear", 32'h3004, 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1, 1'b0, 32'd5);

        // Counter wrap and PC+8 wrap.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        bus.npc = 32'hFFFF_FFFC; step();
        chk_ifid("cnt_wrap", 32'hFFFF_FFFC, 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1, 1'b0,
                 32'd0);
        bus.npc = 32'h3000; step();
`ifdef FETCH_ADDR_CHECK_EN
        chk_ifid("pc8_wrap", 32'h3000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b1, 32'd1);
`else
        chk_ifid("pc8_wrap", 32'h3000, 32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b0,
                 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
